// File: rtl/mips_pkg.sv
// Shared encodings, ALU control and pipeline-register layouts for the 5-stage MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int DMEM_WORDS = 10;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  pc;
  } ifid_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [9:0]  pc;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        zero;
    logic [9:0]  target;
    logic [31:0] alu_res;
    logic [31:0] reg_b;
    logic [4:0]  wr;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  wr;
    logic [31:0] rdata;
    logic [31:0] alu_res;
    logic [9:0]  pc;
  } memwb_t;

  // beq always subtracts; only R-type looks at funct
  function automatic alu_ctrl_e alu_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_ctrl_e c;
    c = ALU_ADD;
    if (alu_op == ALUOP_SUB) c = ALU_SUB;
    else if (alu_op == ALUOP_FUNCT) begin
      case (funct)
        FN_SUB:  c = ALU_SUB;
        FN_AND:  c = ALU_AND;
        FN_OR:   c = ALU_OR;
        FN_SLT:  c = ALU_SLT;
        default: c = ALU_ADD;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU for the EX stage: add/sub/and/or/signed slt with a zero flag.
module mips_alu
  import mips_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = a + b;
    case (alu_ctrl_e'(ctrl))
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      default: ;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_pipeline.sv
// 5-stage MIPS subset core with flat debug ports; branches resolve in MEM with a 3-slot flush.
// Define PIPE_FWD_EN to forward EX/MEM and MEM/WB results into the EX operands.
module mips_pipeline
  import mips_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "imem.hex"
) (
  input  logic          clk,
  input  logic          reset,
  output logic          PCSrc_MEMIF,
  output logic [9:0]    PCJump,
  output logic [31:0]   instruction,
  output logic [9:0]    PC_IFID,
  output logic          regWrite_WBID,
  output logic [4:0]    writeRegister_WBID,
  output logic [31:0]   writeData_WBID,
  output logic [1023:0] Registers,
  output logic          RegDst_IDEX,
  output logic          ALUSrc_IDEX,
  output logic          Branch_IDEX,
  output logic          MemRead_IDEX,
  output logic          MemWrite_IDEX,
  output logic          MemToReg_IDEX,
  output logic          RegWrite_IDEX,
  output logic [1:0]    ALUOp_IDEX,
  output logic [9:0]    PC_IDEX,
  output logic [31:0]   regA_IDEX,
  output logic [31:0]   regB_IDEX,
  output logic [31:0]   signExtend,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic          Branch_EXMEM,
  output logic          MemRead_EXMEM,
  output logic          MemWrite_EXMEM,
  output logic          MemToReg_EXMEM,
  output logic          RegWrite_EXMEM,
  output logic          zero,
  output logic [9:0]    CurrentPC_EXMEM,
  output logic [31:0]   ALUResult_EXMEM,
  output logic [31:0]   regB_EXMEM,
  output logic [4:0]    wr_EXMEM,
  output logic [319:0]  Memorias,
  output logic          MemToReg_MEMWB,
  output logic [31:0]   readData_MEMWB,
  output logic [31:0]   ALUResult_MEMWB,
  output logic [9:0]    CurrentPC_MEMWB
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0] imem [IMEM_DEPTH];

  logic [9:0]            pc_q, pc_d;
  ifid_t                 ifid_q, ifid_d;
  idex_t                 idex_q, idex_d;
  exmem_t                exmem_q, exmem_d;
  memwb_t                memwb_q, memwb_d;
  logic [31:0][31:0]     rf_q;
  logic [DMEM_WORDS-1:0][31:0] ram_q;

  logic          flush;
  logic [IAW-1:0] imem_idx;
  logic [31:0]   wb_data;

  assign flush    = exmem_q.branch & exmem_q.zero;
  assign imem_idx = IAW'(32'(pc_q) % 32'(IMEM_DEPTH));
  assign wb_data  = memwb_q.mem_to_reg ? memwb_q.rdata : memwb_q.alu_res;

  // IF
  always_comb begin
    pc_d         = flush ? exmem_q.target : pc_q + 10'd1;
    ifid_d.pc    = pc_q + 10'd1;
    ifid_d.instr = flush ? 32'd0 : imem[imem_idx];
  end

  // ID
  logic [5:0]  id_op, id_fn;
  logic [4:0]  id_rs, id_rt;
  ctrl_t       id_ctrl;
  logic [31:0] id_a, id_b;

  assign id_op = ifid_q.instr[31:26];
  assign id_fn = ifid_q.instr[5:0];
  assign id_rs = ifid_q.instr[25:21];
  assign id_rt = ifid_q.instr[20:16];

  always_comb begin
    id_ctrl = '0;
    case (id_op)
      OP_RTYPE: if (id_fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
        id_ctrl.reg_dst   = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        id_ctrl.branch = 1'b1;
        id_ctrl.alu_op = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // Same-cycle WB write is visible to the instruction being decoded
  always_comb begin
    id_a = rf_q[id_rs];
    id_b = rf_q[id_rt];
    if (memwb_q.reg_write && memwb_q.wr != 5'd0 && memwb_q.wr == id_rs) id_a = wb_data;
    if (memwb_q.reg_write && memwb_q.wr != 5'd0 && memwb_q.wr == id_rt) id_b = wb_data;
  end

  always_comb begin
    idex_d.ctrl  = flush ? '0 : id_ctrl;
    idex_d.pc    = ifid_q.pc;
    idex_d.reg_a = id_a;
    idex_d.reg_b = id_b;
    idex_d.sext  = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
    idex_d.rs    = id_rs;
    idex_d.rt    = id_rt;
    idex_d.rd    = ifid_q.instr[15:11];
  end

  // EX
  logic [31:0] op_a, op_b, alu_b, alu_res;
  logic [3:0]  alu_ctl;
  logic        alu_zero;

  always_comb begin
    op_a = idex_q.reg_a;
    op_b = idex_q.reg_b;
`ifdef PIPE_FWD_EN
    if (memwb_q.reg_write && memwb_q.wr != 5'd0 && memwb_q.wr == idex_q.rs) op_a = wb_data;
    if (memwb_q.reg_write && memwb_q.wr != 5'd0 && memwb_q.wr == idex_q.rt) op_b = wb_data;
    if (exmem_q.reg_write && exmem_q.wr != 5'd0 && exmem_q.wr == idex_q.rs) op_a = exmem_q.alu_res;
    if (exmem_q.reg_write && exmem_q.wr != 5'd0 && exmem_q.wr == idex_q.rt) op_b = exmem_q.alu_res;
`endif
  end

  assign alu_b   = idex_q.ctrl.alu_src ? idex_q.sext : op_b;
  assign alu_ctl = alu_ctrl(idex_q.ctrl.alu_op, idex_q.sext[5:0]);

  mips_alu u_alu (
    .ctrl   (alu_ctl),
    .a      (op_a),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    exmem_d.branch     = idex_q.ctrl.branch     & ~flush;
    exmem_d.mem_read   = idex_q.ctrl.mem_read   & ~flush;
    exmem_d.mem_write  = idex_q.ctrl.mem_write  & ~flush;
    exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg & ~flush;
    exmem_d.reg_write  = idex_q.ctrl.reg_write  & ~flush;
    exmem_d.zero       = alu_zero;
    exmem_d.target     = idex_q.pc + idex_q.sext[9:0];
    exmem_d.alu_res    = alu_res;
    exmem_d.reg_b      = op_b;
    exmem_d.wr         = idex_q.ctrl.reg_dst ? idex_q.rd : idex_q.rt;
  end

  // MEM: only the low nibble addresses the 10-word RAM; words 10..15 read 0 and drop writes
  logic [3:0]  mem_idx;
  logic        mem_ok;
  logic [31:0] mem_rdata;

  assign mem_idx   = exmem_q.alu_res[3:0];
  assign mem_ok    = mem_idx < 4'(DMEM_WORDS);
  assign mem_rdata = mem_ok ? ram_q[mem_idx] : 32'd0;

  always_comb begin
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.wr         = exmem_q.wr;
    memwb_d.rdata      = mem_rdata;
    memwb_d.alu_res    = exmem_q.alu_res;
    memwb_d.pc         = exmem_q.target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rf_q <= '0;
    else if (memwb_q.reg_write && memwb_q.wr != 5'd0) rf_q[memwb_q.wr] <= wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ram_q <= '0;
    else if (exmem_q.mem_write && mem_ok) ram_q[mem_idx] <= exmem_q.reg_b;
  end

  assign PCSrc_MEMIF        = flush;
  assign PCJump             = exmem_q.target;
  assign instruction        = ifid_q.instr;
  assign PC_IFID            = ifid_q.pc;
  assign regWrite_WBID      = memwb_q.reg_write;
  assign writeRegister_WBID = memwb_q.wr;
  assign writeData_WBID     = wb_data;
  assign Registers          = rf_q;
  assign RegDst_IDEX        = idex_q.ctrl.reg_dst;
  assign ALUSrc_IDEX        = idex_q.ctrl.alu_src;
  assign Branch_IDEX        = idex_q.ctrl.branch;
  assign MemRead_IDEX       = idex_q.ctrl.mem_read;
  assign MemWrite_IDEX      = idex_q.ctrl.mem_write;
  assign MemToReg_IDEX      = idex_q.ctrl.mem_to_reg;
  assign RegWrite_IDEX      = idex_q.ctrl.reg_write;
  assign ALUOp_IDEX         = idex_q.ctrl.alu_op;
  assign PC_IDEX            = idex_q.pc;
  assign regA_IDEX          = idex_q.reg_a;
  assign regB_IDEX          = idex_q.reg_b;
  assign signExtend         = idex_q.sext;
  assign rs                 = idex_q.rs;
  assign rt                 = idex_q.rt;
  assign rd                 = idex_q.rd;
  assign Branch_EXMEM       = exmem_q.branch;
  assign MemRead_EXMEM      = exmem_q.mem_read;
  assign MemWrite_EXMEM     = exmem_q.mem_write;
  assign MemToReg_EXMEM     = exmem_q.mem_to_reg;
  assign RegWrite_EXMEM     = exmem_q.reg_write;
  assign zero               = exmem_q.zero;
  assign CurrentPC_EXMEM    = exmem_q.target;
  assign ALUResult_EXMEM    = exmem_q.alu_res;
  assign regB_EXMEM         = exmem_q.reg_b;
  assign wr_EXMEM           = exmem_q.wr;
  assign Memorias           = ram_q;
  assign MemToReg_MEMWB     = memwb_q.mem_to_reg;
  assign readData_MEMWB     = memwb_q.rdata;
  assign ALUResult_MEMWB    = memwb_q.alu_res;
  assign CurrentPC_MEMWB    = memwb_q.pc;

endmodule

// File: tb/tb_mips_pipeline.sv
// Directed bench for mips_pipeline: program image and initial data are poked into the DUT hierarchy.
module tb_mips_pipeline;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          PCSrc_MEMIF, regWrite_WBID;
  logic [9:0]    PCJump, PC_IFID, PC_IDEX, CurrentPC_EXMEM, CurrentPC_MEMWB;
  logic [31:0]   instruction, writeData_WBID, regA_IDEX, regB_IDEX, signExtend;
  logic [31:0]   ALUResult_EXMEM, regB_EXMEM, readData_MEMWB, ALUResult_MEMWB;
  logic [4:0]    writeRegister_WBID, rs, rt, rd, wr_EXMEM;
  logic [1023:0] Registers;
  logic [319:0]  Memorias;
  logic          RegDst_IDEX, ALUSrc_IDEX, Branch_IDEX, MemRead_IDEX, MemWrite_IDEX;
  logic          MemToReg_IDEX, RegWrite_IDEX;
  logic [1:0]    ALUOp_IDEX;
  logic          Branch_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, MemToReg_EXMEM, RegWrite_EXMEM, zero;
  logic          MemToReg_MEMWB;

  mips_pipeline dut (
    .clk(clk), .reset(reset),
    .PCSrc_MEMIF(PCSrc_MEMIF), .PCJump(PCJump), .instruction(instruction), .PC_IFID(PC_IFID),
    .regWrite_WBID(regWrite_WBID), .writeRegister_WBID(writeRegister_WBID),
    .writeData_WBID(writeData_WBID), .Registers(Registers),
    .RegDst_IDEX(RegDst_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX), .Branch_IDEX(Branch_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX), .MemToReg_IDEX(MemToReg_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .ALUOp_IDEX(ALUOp_IDEX), .PC_IDEX(PC_IDEX),
    .regA_IDEX(regA_IDEX), .regB_IDEX(regB_IDEX), .signExtend(signExtend),
    .rs(rs), .rt(rt), .rd(rd),
    .Branch_EXMEM(Branch_EXMEM), .MemRead_EXMEM(MemRead_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .MemToReg_EXMEM(MemToReg_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM), .zero(zero),
    .CurrentPC_EXMEM(CurrentPC_EXMEM), .ALUResult_EXMEM(ALUResult_EXMEM),
    .regB_EXMEM(regB_EXMEM), .wr_EXMEM(wr_EXMEM), .Memorias(Memorias),
    .MemToReg_MEMWB(MemToReg_MEMWB), .readData_MEMWB(readData_MEMWB),
    .ALUResult_MEMWB(ALUResult_MEMWB), .CurrentPC_MEMWB(CurrentPC_MEMWB)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'd0;
  endtask

  logic [31:0][31:0] exp_rf;
  logic [9:0][31:0]  exp_ram;

  initial begin
    #1;
    clear_imem();
    dut.imem[0]  = rtype(1, 2, 3, 6'h20);        // add $3,$1,$2
    dut.imem[3]  = itype(6'h23, 0, 1, 16'd0);    // lw  $1,0($0)
    dut.imem[4]  = itype(6'h04, 0, 0, 16'd3);    // beq $0,$0,+3 -> 8
    dut.imem[5]  = rtype(1, 2, 5, 6'h20);        // shadowed by branch
    dut.imem[6]  = rtype(2, 2, 6, 6'h20);
    dut.imem[7]  = rtype(2, 2, 7, 6'h20);
    dut.imem[8]  = itype(6'h2B, 0, 3, 16'd4);    // sw $3,4($0)
    dut.imem[9]  = itype(6'h2B, 0, 2, 16'd12);   // sw $2,12($0): out of range
    dut.imem[10] = rtype(2, 1, 8, 6'h22);        // sub $8,$2,$1
    dut.imem[11] = rtype(2, 3, 9, 6'h24);        // and $9,$2,$3
    dut.imem[12] = rtype(2, 3, 10, 6'h25);       // or  $10,$2,$3
    dut.imem[15] = rtype(8, 2, 11, 6'h2A);       // slt $11,$8,$2 (signed)
    dut.imem[17] = itype(6'h23, 0, 13, 16'd4);   // lw  $13,4($0)

    // reset held for two edges
    tick(2);
    check("rst_pc_ifid", PC_IFID, 10'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_regs", Registers, '0);
    check("rst_ram", Memorias, '0);
    check("rst_ctrl", {RegDst_IDEX, ALUSrc_IDEX, Branch_IDEX, MemRead_IDEX, MemWrite_IDEX,
                       MemToReg_IDEX, RegWrite_IDEX, Branch_EXMEM, MemRead_EXMEM, MemWrite_EXMEM,
                       MemToReg_EXMEM, RegWrite_EXMEM, zero, MemToReg_MEMWB, regWrite_WBID,
                       PCSrc_MEMIF}, '0);
    check("rst_data", {PCJump, PC_IDEX, regA_IDEX, regB_IDEX, signExtend, ALUResult_EXMEM,
                       regB_EXMEM, readData_MEMWB, ALUResult_MEMWB, writeData_WBID,
                       CurrentPC_MEMWB, rs, rt, rd, wr_EXMEM, writeRegister_WBID, ALUOp_IDEX}, '0);

    reset = 1'b1;
    dut.rf_q[1]  = 32'd2;
    dut.rf_q[2]  = 32'd3;
    dut.ram_q[0] = 32'd5;

    tick(1);  // E1
    check("pc_ifid_1", PC_IFID, 10'd1);
    check("instr_add", instruction, 32'h0022_1820);
    tick(1);  // E2
    check("pc_ifid_2", PC_IFID, 10'd2);
    check("idex_add", {RegDst_IDEX, ALUSrc_IDEX, RegWrite_IDEX, ALUOp_IDEX, regA_IDEX, regB_IDEX, rd},
          {1'b1, 1'b0, 1'b1, 2'b10, 32'd2, 32'd3, 5'd3});
    tick(1);  // E3
    check("pc_ifid_3", PC_IFID, 10'd3);
    check("exmem_add", {RegWrite_EXMEM, wr_EXMEM, ALUResult_EXMEM}, {1'b1, 5'd3, 32'd5});
    tick(1);  // E4
    check("reg3_before_wb", Registers[127:96], 32'd0);
    check("wb_add", {regWrite_WBID, writeRegister_WBID, writeData_WBID}, {1'b1, 5'd3, 32'd5});
    tick(1);  // E5
    check("reg3_add", Registers[127:96], 32'd5);
    tick(2);  // E7: beq in EX/MEM
    check("reg1_before_lw", Registers[63:32], 32'd2);
    check("beq_taken", {PCSrc_MEMIF, PCJump, zero}, {1'b1, 10'd8, 1'b1});
    tick(1);  // E8
    check("reg1_lw", Registers[63:32], 32'd5);
    check("flush_ifid", {PCSrc_MEMIF, instruction}, {1'b0, 32'd0});
    check("flush_idex", {RegWrite_IDEX, Branch_IDEX, MemWrite_IDEX}, 3'b000);
    tick(1);  // E9
    check("pc_after_jump", {PC_IFID, instruction}, {10'd9, 32'hAC03_0004});
    tick(3);  // E12
    check("ram_word4", Memorias[159:128], 32'd5);
    tick(2);  // E14
    check("wb_sub", {regWrite_WBID, writeRegister_WBID, writeData_WBID},
          {1'b1, 5'd8, 32'hFFFF_FFFE});
    exp_ram = '0;
    exp_ram[0] = 32'd5;
    exp_ram[4] = 32'd5;
    check("ram_oob_store", Memorias, exp_ram);
    tick(16); // E30
    exp_rf = '0;
    exp_rf[1]  = 32'd5;
    exp_rf[2]  = 32'd3;
    exp_rf[3]  = 32'd5;
    exp_rf[8]  = 32'hFFFF_FFFE;
    exp_rf[9]  = 32'd1;
    exp_rf[10] = 32'd7;
    exp_rf[11] = 32'd1;
    exp_rf[13] = 32'd5;
    check("regs_final", Registers, exp_rf);

    // asynchronous reset in the middle of a cycle
    #3 reset = 1'b0;
    #1;
    check("async_rst_regs", Registers, '0);
    check("async_rst_ram", Memorias, '0);
    check("async_rst_pipe", {PC_IFID, instruction, RegWrite_EXMEM, regWrite_WBID}, '0);
    reset = 1'b1;
    tick(1);
    check("restart_pc0", {PC_IFID, instruction}, {10'd1, 32'h0022_1820});

`ifdef PIPE_FWD_EN
    reset = 1'b0;
    #1;
    clear_imem();
    dut.imem[0] = rtype(1, 2, 3, 6'h20);         // add $3,$1,$2
    dut.imem[1] = rtype(3, 3, 4, 6'h20);         // add $4,$3,$3 (EX/MEM forward)
    dut.imem[2] = itype(6'h2B, 0, 4, 16'd0);     // sw $4,0($0)  (EX/MEM forward of data)
    reset = 1'b1;
    dut.rf_q[1] = 32'd2;
    dut.rf_q[2] = 32'd3;
    tick(10);
    check("fwd_reg4", Registers[159:128], 32'd10);
    check("fwd_sw", Memorias[31:0], 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
